ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 127 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller in front of a simple dual-port RAM with a
// one-cycle read latency. Entries are held in the RAM and then prefetched
// into a two-entry output buffer. The buffer head drives out_data_o
// directly from a register. Two buffer slots let the block sustain one push
// and one pop per cycle even though each RAM read takes a cycle to return.
module ram_fifo_ctrl #(
   parameter int WORD_SIZE = 32,
   parameter int ADDR_SIZE = 3,
   parameter int NUM_WORDS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   input  logic [WORD_SIZE-1:0] in_data_i,
   output logic                 in_ready_o,
   output logic                 out_valid_o,
   output logic [WORD_SIZE-1:0] out_data_o,
   input  logic                 out_ready_i,
   output logic                 ram_wr_en_o,
   output logic [ADDR_SIZE-1:0] ram_wr_addr_o,
   output logic [WORD_SIZE-1:0] ram_wr_word_o,
   output logic                 ram_rd_en_o,
   output logic [ADDR_SIZE-1:0] ram_rd_addr_o,
   input  logic [WORD_SIZE-1:0] ram_rd_word_i,
   output logic [ADDR_SIZE+1:0] count_o,
   output logic                 full_o,
   output logic                 empty_o
);

   localparam int CW  = ADDR_SIZE + 1;   // ram_cnt width, holds 0..NUM_WORDS
   localparam int CNW = ADDR_SIZE + 2;   // total count width, up to NUM_WORDS+2
   localparam logic [CW-1:0] DEPTH = CW'(NUM_WORDS);

   logic [ADDR_SIZE-1:0]            wp_q, wp_d;
   logic [ADDR_SIZE-1:0]            rp_q, rp_d;
   logic [CW-1:0]                   ram_cnt_q, ram_cnt_d;
   logic                            inflight_q, inflight_d;
   logic [1:0]                      buf_cnt_q, buf_cnt_d;
   logic [1:0][WORD_SIZE-1:0]       buf_q, buf_d;

   logic                            push, pop, rd;
   logic [2:0]                      occ;

   // Handshakes and RAM strobes. Readiness depends only on state and flush,
   // so there is no combinational path from out_ready_i to in_ready_o.
   always_comb begin
      in_ready_o  = !flush_i && (ram_cnt_q < DEPTH);
      push        = in_valid_i && in_ready_o;
      out_valid_o = (buf_cnt_q != 2'd0);
      pop         = out_valid_o && out_ready_i;
      // Buffer slots already claimed once this cycle's pop is taken out;
      // a read is issued only if its data will have a free slot on return.
      occ         = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(pop);
      // ram_cnt_q only counts entries written at earlier edges, so a word is
      // never read in the cycle it is written.
      rd          = !flush_i && (ram_cnt_q != '0) && (occ < 3'd2);
   end

   assign ram_wr_en_o   = push;
   assign ram_wr_addr_o = wp_q;
   assign ram_wr_word_o = in_data_i;
   assign ram_rd_en_o   = rd;
   assign ram_rd_addr_o = rp_q;
   assign out_data_o    = buf_q[0];

   assign count_o = CNW'(ram_cnt_q) + CNW'(inflight_q) + CNW'(buf_cnt_q);
   assign full_o  = (ram_cnt_q == DEPTH);
   assign empty_o = (count_o == '0);

   // Next state for the pointers, RAM occupancy and the read-in-flight flag.
   always_comb begin
      wp_d       = wp_q;
      rp_d       = rp_q;
      ram_cnt_d  = ram_cnt_q;
      inflight_d = rd;
      if (push) wp_d = wp_q + ADDR_SIZE'(1);
      if (rd)   rp_d = rp_q + ADDR_SIZE'(1);
      ram_cnt_d = ram_cnt_q + CW'(push) - CW'(rd);
      if (flush_i) begin
         wp_d       = '0;
         rp_d       = '0;
         ram_cnt_d  = '0;
         inflight_d = 1'b0;
      end
   end

   // Output buffer: a pop shifts the tail into the head first, then any
   // returning read data lands behind whatever remains, which keeps order
   // when a pop and a capture share an edge. The head changes only on a pop
   // or when the buffer is empty, so it holds while stalled.
   always_comb begin
      buf_d     = buf_q;
      buf_cnt_d = buf_cnt_q;
      if (pop) begin
         buf_d[0]  = buf_q[1];
         buf_cnt_d = buf_cnt_q - 2'd1;
      end
      if (inflight_q && !flush_i) begin
         if (buf_cnt_d == 2'd0) buf_d[0] = ram_rd_word_i;
         else                   buf_d[1] = ram_rd_word_i;
         buf_cnt_d = buf_cnt_d + 2'd1;
      end
      // Flush drops the contents; in-flight read data is simply not captured.
      if (flush_i) buf_cnt_d = 2'd0;
   end

   // State registers, cleared asynchronously so nothing survives a reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q       <= '0;
         rp_q       <= '0;
         ram_cnt_q  <= '0;
         inflight_q <= 1'b0;
         buf_cnt_q  <= 2'd0;
         buf_q      <= '0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         ram_cnt_q  <= ram_cnt_d;
         inflight_q <= inflight_d;
         buf_cnt_q  <= buf_cnt_d;
         buf_q      <= buf_d;
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a behavioural RAM, a scoreboard queue fed on
// accepted pushes and drained on pops, a small vector table for the
// single-word latency case, and directed sequences for fill, streaming,
// random back-pressure, flush and asynchronous reset.
module tb_ram_fifo_ctrl;

   localparam int WS = 32;
   localparam int AS = 3;
   localparam int NW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_i;
   logic          in_valid_i;
   logic [WS-1:0] in_data_i;
   logic          in_ready_o;
   logic          out_valid_o;
   logic [WS-1:0] out_data_o;
   logic          out_ready_i;
   logic          ram_wr_en_o;
   logic [AS-1:0] ram_wr_addr_o;
   logic [WS-1:0] ram_wr_word_o;
   logic          ram_rd_en_o;
   logic [AS-1:0] ram_rd_addr_o;
   logic [WS-1:0] ram_rd_word_i;
   logic [AS+1:0] count_o;
   logic          full_o;
   logic          empty_o;

   ram_fifo_ctrl #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .NUM_WORDS(NW)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
      .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
      .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_word_o(ram_wr_word_o),
      .ram_rd_en_o(ram_rd_en_o), .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_word_i(ram_rd_word_i),
      .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
   );

   always #5 clk = ~clk;

   // RAM model: synchronous write, registered read data one cycle later.
   logic [WS-1:0] mem [NW];
   always @(posedge clk) begin
      if (ram_wr_en_o) mem[ram_wr_addr_o] <= ram_wr_word_o;
      if (ram_rd_en_o) ram_rd_word_i <= mem[ram_rd_addr_o];
   end

   int checks = 0;
   int errors = 0;
   int npop   = 0;
   logic [WS-1:0] sbq [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs just after the edge; return at the falling
   // edge so callers sample settled outputs away from the clock edge.
   task automatic step(input logic v, input logic [WS-1:0] d, input logic r, input logic f);
      @(posedge clk);
      #1;
      in_valid_i  = v;
      in_data_i   = d;
      out_ready_i = r;
      flush_i     = f;
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 200 && !empty_o; k++) step(1'b0, '0, 1'b1, 1'b0);
      chk({name, "_empty"}, 32'(empty_o), 32'd1);
      chk({name, "_sb_left"}, 32'(sbq.size()), 32'd0);
   endtask

   // Scoreboard monitor: pops are compared against the oldest accepted push,
   // and a stalled head must not change.
   initial begin
      logic          prev_stall;
      logic [WS-1:0] prev_data;
      logic [WS-1:0] exp;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            sbq.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && out_valid_o) chk("hold", out_data_o, prev_data);
            if (out_valid_o && out_ready_i) begin
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_pop actual=%h required=<none>", out_data_o);
               end else begin
                  exp = sbq.pop_front();
                  chk("sb_data", out_data_o, exp);
                  npop++;
               end
            end
            if (flush_i) sbq.delete();
            else if (in_valid_i && in_ready_o) sbq.push_back(in_data_i);
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
         end
      end
   end

   typedef struct {
      logic          iv;
      logic [WS-1:0] d;
      logic          ordy;
      logic          e_irdy;
      logic          e_wr;
      logic          e_rd;
      logic          e_ov;
      logic [WS-1:0] e_od;
      logic [4:0]    e_cnt;
      logic          e_empty;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int acc, wcnt, npop0, found;
      logic v, r;

      // single word through an empty block, pushed at edge 0
      vecs[0] = '{1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        5'd0, 1'b1};
      vecs[1] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        5'd1, 1'b0};
      vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'd1, 1'b0};
      vecs[3] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 5'd1, 1'b0};
      vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 1'b1};

      rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
      #3;
      // reset values before any clock edge
      chk("rst_in_ready", 32'(in_ready_o), 32'd1);
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_out_data", out_data_o, 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_empty", 32'(empty_o), 32'd1);
      chk("rst_full", 32'(full_o), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_rd_en", 32'(ram_rd_en_o), 32'd0);
      chk("post_rst_wr_en", 32'(ram_wr_en_o), 32'd0);

      // vector table
      for (int i = 0; i < 5; i++) begin
         step(vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0);
         chk($sformatf("v%0d_in_ready", i), 32'(in_ready_o), 32'(vecs[i].e_irdy));
         chk($sformatf("v%0d_wr_en", i), 32'(ram_wr_en_o), 32'(vecs[i].e_wr));
         if (vecs[i].e_wr) chk($sformatf("v%0d_wr_word", i), ram_wr_word_o, vecs[i].d);
         chk($sformatf("v%0d_rd_en", i), 32'(ram_rd_en_o), 32'(vecs[i].e_rd));
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid_o), 32'(vecs[i].e_ov));
         if (vecs[i].e_ov) chk($sformatf("v%0d_out_data", i), out_data_o, vecs[i].e_od);
         chk($sformatf("v%0d_count", i), 32'(count_o), 32'(vecs[i].e_cnt));
         chk($sformatf("v%0d_empty", i), 32'(empty_o), 32'(vecs[i].e_empty));
      end

      // fill with the sink stalled: 10 of 12 accepted, then drain in order
      acc = 0;
      for (int i = 1; i <= 12; i++) begin
         step(1'b1, 32'(i), 1'b0, 1'b0);
         if (in_ready_o) acc++;
         else chk("fill_no_wr", 32'(ram_wr_en_o), 32'd0);
      end
      chk("fill_accepted", 32'(acc), 32'd10);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("fill_count", 32'(count_o), 32'd10);
      chk("fill_in_ready", 32'(in_ready_o), 32'd0);
      chk("fill_full", 32'(full_o), 32'd1);
      chk("fill_head", out_data_o, 32'd1);
      drain("fill");

      // streaming: after priming, one pop every cycle at constant occupancy
      for (int i = 0; i < 104; i++) begin
         step(1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0);
         if (i >= 3 && i < 100) begin
            chk("stream_valid", 32'(out_valid_o), 32'd1);
            chk("stream_count", 32'(count_o), 32'd3);
         end
      end
      drain("stream");

      // random back-pressure, 1000 words
      wcnt = 0;
      npop0 = npop;
      for (int c = 0; c < 20000 && wcnt < 1000; c++) begin
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) != 0);
         step(v, 32'h5000_0000 + 32'(wcnt), r, 1'b0);
         if (v && in_ready_o) wcnt++;
      end
      chk("rand_pushed", 32'(wcnt), 32'd1000);
      drain("rand");
      chk("rand_popped", 32'(npop - npop0), 32'd1000);

      // flush with 5 entries held and one read in flight
      for (int i = 0; i < 6; i++) step(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
      chk("fl_pre_count", 32'(count_o), 32'd6);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("fl_pop_rd_en", 32'(ram_rd_en_o), 32'd1);
      step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
      chk("fl_count_before", 32'(count_o), 32'd5);
      chk("fl_wr_blocked", 32'(ram_wr_en_o), 32'd0);
      chk("fl_rd_blocked", 32'(ram_rd_en_o), 32'd0);
      chk("fl_in_ready", 32'(in_ready_o), 32'd0);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("fl_count_after", 32'(count_o), 32'd0);
      chk("fl_out_valid", 32'(out_valid_o), 32'd0);
      chk("fl_empty", 32'(empty_o), 32'd1);
      step(1'b1, 32'h1, 1'b1, 1'b0);
      found = 0;
      for (int k = 0; k < 10 && found == 0; k++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         if (out_valid_o) begin
            found = 1;
            chk("fl_first_word", out_data_o, 32'h1);
            chk("fl_first_latency", 32'(k), 32'd2);
         end
      end
      if (found == 0) begin
         checks++;
         errors++;
         $display("FAIL fl_first_timeout actual=no_valid required=valid");
      end
      drain("flush");

      // asynchronous reset mid-cycle while full
      for (int i = 0; i < 12; i++) step(1'b1, 32'h700 + 32'(i), 1'b0, 1'b0);
      chk("ar_pre_full", 32'(full_o), 32'd1);
      #2;
      in_valid_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("ar_in_ready", 32'(in_ready_o), 32'd1);
      chk("ar_out_valid", 32'(out_valid_o), 32'd0);
      chk("ar_out_data", out_data_o, 32'd0);
      chk("ar_wr_en", 32'(ram_wr_en_o), 32'd0);
      chk("ar_rd_en", 32'(ram_rd_en_o), 32'd0);
      chk("ar_count", 32'(count_o), 32'd0);
      chk("ar_full", 32'(full_o), 32'd0);
      chk("ar_empty", 32'(empty_o), 32'd1);
      @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
      step(1'b0, '0, 1'b1, 1'b0);
      chk("ar_post_valid", 32'(out_valid_o), 32'd0);
      chk("ar_post_count", 32'(count_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
